// File: rtl/demux1x2_32bit_pipe_pkg.sv
// -----------------------------------------------------------------------------
// demux1x2_32bit_pipe_pkg
// Shared definitions for the registered 1-to-2 result demultiplexer:
//   DATA_W      - default datapath width
//   CH0 / CH1   - values of in_sel that steer to channel 0 / channel 1
//   ch_state_e  - occupancy state of one output slot
// -----------------------------------------------------------------------------
package demux1x2_32bit_pipe_pkg;

  localparam int DATA_W = 32;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage : demux1x2_32bit_pipe_pkg

// File: rtl/demux_out_slot.sv
// -----------------------------------------------------------------------------
// demux_out_slot
// One-entry valid/ready output register for one demux channel.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   wr_req      - upstream word is valid and steered to this slot
//   wr_data     - word to load
//   can_accept  - slot is empty or is being drained this cycle
//   out_data    - held word (keeps its last value after drain)
//   out_valid   - slot holds a word
//   out_ready   - consumer takes the held word
// -----------------------------------------------------------------------------
module demux_out_slot
  import demux1x2_32bit_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             can_accept,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  ch_state_e        state_r;
  ch_state_e        state_nxt_s;
  logic [WIDTH-1:0] data_r;
  logic             drain_s;
  logic             load_s;

  // A full slot that is being drained frees its entry in the same cycle,
  // which is what gives 1 word/cycle throughput.
  assign drain_s    = (state_r == CH_FULL) & out_ready;
  assign can_accept = (state_r == CH_EMPTY) | drain_s;
  assign load_s     = wr_req & can_accept;

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= CH_EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: load wins over drain so drain+load stays FULL.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      CH_EMPTY: begin
        if (load_s) state_nxt_s = CH_FULL;
        else        state_nxt_s = CH_EMPTY;
      end
      CH_FULL: begin
        if (load_s)       state_nxt_s = CH_FULL;
        else if (drain_s) state_nxt_s = CH_EMPTY;
        else              state_nxt_s = CH_FULL;
      end
      default: state_nxt_s = CH_EMPTY;
    endcase
  end

  // Data register: only written on load, so a stalled word stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r <= {WIDTH{1'b0}};
    end else if (load_s) begin
      data_r <= wr_data;
    end
  end

  assign out_data  = data_r;
  assign out_valid = (state_r == CH_FULL);

endmodule : demux_out_slot

// File: rtl/demux1x2_32bit_pipe.sv
// -----------------------------------------------------------------------------
// demux1x2_32bit_pipe
// Registered 1-to-2 demultiplexer steering the ALU result to one of two
// valid/ready consumers, each with a one-entry output register.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   in_data/in_sel/in_valid - input word, destination (0->ch0, 1->ch1), valid
//   in_ready                - word accepted this cycle (0 while in reset)
//   out0_* / out1_*         - per-channel data/valid/ready
// Optional (macro DEMUX_STATS_EN):
//   cnt_clr                 - synchronous clear of both drain counters
//   cnt0 / cnt1             - 16-bit wrapping drain counters per channel
// -----------------------------------------------------------------------------
module demux1x2_32bit_pipe
  import demux1x2_32bit_pipe_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready
`ifdef DEMUX_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  logic can_accept0_s;
  logic can_accept1_s;

  // in_ready only looks at the selected channel, so a stalled channel never
  // blocks traffic bound for the other one.
  assign in_ready = rst_n & ((in_sel == CH1) ? can_accept1_s : can_accept0_s);

  demux_out_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (in_valid & (in_sel == CH0)),
    .wr_data    (in_data),
    .can_accept (can_accept0_s),
    .out_data   (out0_data),
    .out_valid  (out0_valid),
    .out_ready  (out0_ready)
  );

  demux_out_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_req     (in_valid & (in_sel == CH1)),
    .wr_data    (in_data),
    .can_accept (can_accept1_s),
    .out_data   (out1_data),
    .out_valid  (out1_valid),
    .out_ready  (out1_ready)
  );

`ifdef DEMUX_STATS_EN
  logic [15:0] cnt0_r;
  logic [15:0] cnt1_r;

  // Drain counters; clear has priority over a coincident drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_r <= 16'h0000;
      cnt1_r <= 16'h0000;
    end else if (cnt_clr) begin
      cnt0_r <= 16'h0000;
      cnt1_r <= 16'h0000;
    end else begin
      if (out0_valid & out0_ready) cnt0_r <= cnt0_r + 16'h0001;
      if (out1_valid & out1_ready) cnt1_r <= cnt1_r + 16'h0001;
    end
  end

  assign cnt0 = cnt0_r;
  assign cnt1 = cnt1_r;
`endif

endmodule : demux1x2_32bit_pipe

// File: doc/demux1x2_32bit_pipe.md
Name: demux1x2_32bit_pipe

Overview:
- Registered 1-to-2 demultiplexer: the steering counterpart of the 32-bit 2:1 operand mux in the ALU datapath.
- Accepts one 32-bit word per cycle on a valid/ready input and routes it to one of two valid/ready output channels, selected by in_sel.
- Each channel has a one-entry output register.
- Sits between the ALU result and its two consumers (e.g. register writeback vs. memory-address path).

Parameters:
- WIDTH, 32, data width of input and both outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  destination: 0 -> channel 0, 1 -> channel 1.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  channel 0 word.
- out0_valid  output  1  channel 0 holds a word.
- out0_ready  input  1  channel 0 consumer takes word.
- out1_data  output  WIDTH  channel 1 word.
- out1_valid  output  1  channel 1 holds a word.
- out1_ready  input  1  channel 1 consumer takes word.

Behaviour:
- Reset (rst_n low, asynchronous): out0_valid = out1_valid = 0; out0_data = out1_data = 0; in_ready forced 0; any buffered word is discarded.
- Per-channel two-state FSM:
  - EMPTY -> FULL on accept with in_sel selecting that channel.
  - FULL -> EMPTY on drain (outX_valid & outX_ready) with no new accept.
  - FULL -> FULL on drain plus same-cycle accept; the new word is loaded.
- Transfer rules:
  - Accept = in_valid & in_ready.
  - Drain = outX_valid & outX_ready.
- in_ready (combinational, out of reset) = channel[in_sel] EMPTY, or channel[in_sel] being drained this cycle. in_ready ignores the unselected channel.
- Latency: an accepted word appears on outX_data/outX_valid the cycle after acceptance. Full throughput of 1 word/cycle when the consumer holds ready high.
- While outX_valid = 1 and outX_ready = 0: outX_data is held stable and the channel is not overwritten.
- Ordering is preserved per channel. There is no ordering guarantee across channels.
- A stalled channel never blocks words destined for the other channel.
- in_data and in_sel are don't-care when in_valid = 0; in_ready may still be asserted.
- outX_data retains its last value after drain; only valid drops.
- Reset mid-transfer: pending words are lost; the first cycle after rst_n deasserts, in_ready = 1 and both valids = 0.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- With the macro defined:
  - Adds outputs cnt0 and cnt1, each 16 bits, counting drains per channel.
  - Both reset to 0 and wrap from 0xFFFF to 0x0000.
  - Adds input cnt_clr (1 bit), which synchronously zeros both counters. If cnt_clr coincides with a drain, the counter becomes 0.
- Without the macro: these ports and registers do not exist, and routing behaviour is identical.

Decomposition:
- Shared package:
  - DATA_W = 32.
  - Channel-select constants CH0 = 1'b0, CH1 = 1'b1.
  - Channel state enum {CH_EMPTY, CH_FULL}.
- Natural sub-module: demux_out_slot, one-entry valid/ready register, instantiated twice. Each instance computes its own load/drain and exposes a can_accept flag; the top level selects can_accept by in_sel for in_ready.

Test Plan:
- Reset -> out0_valid = 0, out1_valid = 0, out0_data = 0, out1_data = 0; in_ready = 0 during reset, 1 on the first cycle after release.
- Streaming: send 0x00000001, 0x00000002, 0x00000003 with in_sel = 0, in_valid = 1 and out0_ready = 1 every cycle -> out0_data shows 1, 2, 3 on consecutive cycles, each one cycle after its accept; out1_valid stays 0.
- Back-pressure: out0_ready = 0 after 0xDEADBEEF lands in channel 0; a further word with in_sel = 0 -> in_ready = 0 and out0_data held at 0xDEADBEEF; raise out0_ready -> the held word drains and the new word is accepted in the same cycle.
- Isolation: channel 0 full and stalled; send 0xCAFEF00D with in_sel = 1 -> in_ready = 1, out1_data = 0xCAFEF00D the next cycle, channel 0 unchanged.
- Async reset mid-stall: both channels full, assert rst_n low between clock edges -> both valids drop immediately; the held words are not presented after release.
- With DEMUX_STATS_EN: 3 drains on channel 1 -> cnt1 = 3 and cnt0 = 0; preload cnt0 = 0xFFFF then drain once on channel 0 -> cnt0 = 0x0000; assert cnt_clr during a drain -> counter reads 0.
